uart_8n1_rx_controller: RTL
===========================

# uart_8n1_rx_controller

Sequencer for the 8N1 UART receiver: it repeatedly arms the receiver, collects each completed byte into a small FIFO, and counts and recovers from frame errors. After an error it holds off until the line has been idle for a programmable number of bit times. It sits between the raw RX pin, the receiver, and the byte consumer, in the receiver's 16x-baud clock domain.

## Interface
- DEPTH, 8: FIFO depth in bytes; must be a power of two, at least 2.
- IDLE_BITS, 10: consecutive idle-high bit times required after an error before re-arming.
- clk_baud_16x  in  1  clock, 16 pulses per baud.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = keep receiving; 0 = stop after the current frame.
- rx  in  1  raw RX line; synchronized internally with 2 flops (reset value 1).
- recv_read  out  1  to receiver; start-receive pulse.
- recv_busy  in  1  from receiver.
- recv_error  in  1  from receiver.
- recv_data  in  8  from receiver.
- out_data  out  8  FIFO head byte; first-word fall-through.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pop; effective only when out_valid=1.
- fifo_level  out  $clog2(DEPTH)+1  bytes stored.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- err_count  out  8  saturating count of errored frames.
- status_clear  in  1  clears overflow and err_count; reset has priority.

## Operation
- Receiver contract:
  - recv_read while idle starts a cycle; recv_busy rises on the next clock.
  - On the edge where recv_busy falls, recv_data holds the new byte and recv_error is a 1-cycle flag for that frame.
- State machine states: IDLE, ARM, WAIT_BUSY, RUN, HOLDOFF.
  - IDLE: recv_read=0. If enable=1, go to ARM.
  - ARM: recv_read=1 for exactly this cycle. If enable=0, go to IDLE (pulse suppressed). Otherwise go to WAIT_BUSY.
  - WAIT_BUSY: if recv_busy=1, go to RUN. If recv_busy is still 0 after 2 cycles, go back to ARM. If enable=0, go to IDLE.
  - RUN: wait for recv_busy=0. In that first cycle (T):
    - If recv_error=0: push recv_data, then go to ARM, or to IDLE if enable=0.
    - If recv_error=1: no push; err_count+1 (saturates at 255); go to HOLDOFF.
    - enable=0 during RUN never aborts the frame.
  - HOLDOFF: counter counts consecutive synchronized-rx=1 cycles; any 0 resets it to 0. At IDLE_BITS*16 go to ARM; if enable=0, go to IDLE.
- FIFO:
  - Push while full is dropped and sets overflow, unless a pop occurs in the same cycle; then both push and pop succeed.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - recv_read=0, out_valid=0, fifo_level=0, overflow=0, err_count=0.
  - out_data is don't-care while out_valid=0.
  - State returns to IDLE; holdoff counter=0; sync flops=1.
- Reset mid-frame: all of the above apply on the next cycle. The receiver shares reset.
- Latency for a good frame:
  - Push at the end of cycle T; out_valid=1 in T+1 if the FIFO was empty.
  - recv_read is high in T+1 (re-arm gap of 1 cycle).
- A pop in cycle C updates out_data/fifo_level in C+1.
- Push and pop in the same cycle: fifo_level is unchanged.
- status_clear and an error in the same cycle: err_count=0 (clear wins).
- rx synchronizer adds 2 cycles before HOLDOFF sees the line.

## Structure
- Shared package uart_8n1_pkg:
  - state enum: IDLE, ARM, WAIT_BUSY, RUN, HOLDOFF.
  - OVERSAMPLE=16.
  - FRAME_BITS=10.
  - ERR_COUNT_W=8.
- Sub-module uart_rx_fifo (DEPTH, width 8, first-word fall-through, level output, same-cycle push/pop when full).
- The receiver is instantiated by the parent, not inside this block.

## Test plan
- Good frame: enable=1, frame 0xA5 at 16x baud -> one recv_read pulse per frame; out_valid=1 with out_data=0xA5; fifo_level=1; err_count=0.
- FIFO overflow: out_ready=0, DEPTH=8, frames 0x01..0x09 -> fifo_level=8; overflow=1; pops yield 0x01..0x08 in order; 0x09 lost.
- Frame error: frame with stop bit 0 -> err_count=1; no push; recv_read stays 0 until 160 consecutive high cycles; next frame 0x3C delivered.
- Holdoff glitch: rx low for 1 cycle after 100 high cycles in HOLDOFF -> re-arm exactly 160 high cycles after the glitch (plus 2-cycle sync delay).
- Disable mid-frame: enable dropped during frame 0x55 -> 0x55 delivered; state IDLE; recv_read remains 0.
- Saturation, clear, and reset:
  - 256 errored frames -> err_count=255.
  - status_clear -> err_count=0, overflow=0.
  - reset mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/uart_8n1_rx_controller_pkg.sv
// uart_8n1_pkg: shared types and constants for the 8N1 receive controller.
//   state_t      controller FSM states
//   OVERSAMPLE   clock pulses per bit time
//   FRAME_BITS   bits per 8N1 frame (start + 8 data + stop)
//   ERR_COUNT_W  width of the saturating frame-error counter
package uart_8n1_pkg;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, RUN, HOLDOFF} state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int FRAME_BITS  = 10;
    localparam int ERR_COUNT_W = 8;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uart_8n1_rx_controller_if.sv
// uart_8n1_rx_controller_if: bundle of RX line, receiver handshake and byte-consumer signals.
//   enable/rx/status_clear   control and raw line into the controller
//   recv_read/busy/error/data handshake with the 8N1 receiver
//   out_data/valid/ready      first-word fall-through byte stream to the consumer
//   fifo_level/overflow/err_count status
//   slave  = controller side, master = environment side
interface uart_8n1_rx_controller_if #(parameter int DEPTH = 8);
    import uart_8n1_pkg::*;

    logic                    enable;
    logic                    rx;
    logic                    recv_read;
    logic                    recv_busy;
    logic                    recv_error;
    logic [7:0]              recv_data;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    overflow;
    logic [ERR_COUNT_W-1:0]  err_count;
    logic                    status_clear;

    modport slave (
        input  enable, rx, recv_busy, recv_error, recv_data, out_ready, status_clear,
        output recv_read, out_data, out_valid, fifo_level, overflow, err_count
    );

    modport master (
        output enable, rx, recv_busy, recv_error, recv_data, out_ready, status_clear,
        input  recv_read, out_data, out_valid, fifo_level, overflow, err_count
    );

endinterface

// File: rtl/uart_8n1_rx_controller_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO with level and sticky overflow.
//   clk_baud_16x, reset  clock and synchronous active-high reset
//   i_push, i_data       write request and byte
//   i_pop                read request, ignored while empty
//   i_clear              clears the sticky overflow flag
//   o_data, o_valid      head byte and not-empty flag
//   o_level              bytes stored
//   o_overflow           a push was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_baud_16x,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic             w_pop;
    logic             w_wr;

    assign w_pop = i_pop && r_level != '0;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_wr  = i_push && (r_level != (AW+1)'(DEPTH) || w_pop);

    always_ff @(posedge clk_baud_16x) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level    <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
            r_overflow <= i_clear ? 1'b0 : (r_overflow || (i_push && !w_wr));
        end
    end

    assign o_data     = r_mem[r_rd];
    assign o_valid    = r_level != '0;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_8n1_rx_controller.sv
// uart_8n1_rx_controller: arms the 8N1 receiver, queues good bytes, counts frame errors
// and waits for a quiet line before re-arming after an error.
//   clk_baud_16x  16x-baud clock
//   reset         synchronous active-high reset, shared with the receiver
//   bus           uart_8n1_rx_controller_if slave: control, receiver handshake, byte stream, status
module uart_8n1_rx_controller
    import uart_8n1_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IDLE_BITS = FRAME_BITS
) (
    input  logic                        clk_baud_16x,
    input  logic                        reset,
    uart_8n1_rx_controller_if.slave     bus
);
    localparam int HOLD_CYC = IDLE_BITS * OVERSAMPLE;
    localparam int HW       = $clog2(HOLD_CYC + 1);

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_recv_read;
    logic                   r_wait;
    logic [HW-1:0]          r_hold;
    logic [ERR_COUNT_W-1:0] r_err_count;
    logic                   w_done;
    logic                   w_push;

    // first RUN cycle with busy low carries the finished frame's data and error flag
    assign w_done = r_state == RUN && !bus.recv_busy;
    assign w_push = w_done && !bus.recv_error;

    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            r_state     <= IDLE;
            r_recv_read <= 1'b0;
            r_wait      <= 1'b0;
            r_hold      <= '0;
            r_err_count <= '0;
        end else begin
            r_recv_read <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state     <= ARM;
                        r_recv_read <= 1'b1;
                    end
                end
                ARM: begin
                    r_wait  <= 1'b0;
                    r_state <= bus.enable ? WAIT_BUSY : IDLE;
                end
                WAIT_BUSY: begin
                    if (bus.recv_busy) begin
                        r_state <= RUN;
                    end else if (!bus.enable) begin
                        r_state <= IDLE;
                    end else if (r_wait) begin
                        r_state     <= ARM;
                        r_recv_read <= 1'b1;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.recv_busy) begin
                        if (bus.recv_error) begin
                            r_state <= HOLDOFF;
                            r_hold  <= '0;
                        end else if (bus.enable) begin
                            r_state     <= ARM;
                            r_recv_read <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                HOLDOFF: begin
                    if (!bus.enable) begin
                        r_state <= IDLE;
                    end else if (!r_sync2) begin
                        r_hold <= '0;
                    end else if (r_hold == HW'(HOLD_CYC - 1)) begin
                        r_state     <= ARM;
                        r_recv_read <= 1'b1;
                        r_hold      <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (bus.status_clear) r_err_count <= '0;
            else if (w_done && bus.recv_error) r_err_count <= sat_inc(r_err_count);
        end
    end

    // the ARM-cycle pulse is gated so dropping enable in that cycle issues no read
    assign bus.recv_read = r_recv_read && bus.enable;
    assign bus.err_count = r_err_count;

    uart_rx_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk_baud_16x(clk_baud_16x),
        .reset(reset),
        .i_push(w_push),
        .i_data(bus.recv_data),
        .i_pop(bus.out_ready),
        .i_clear(bus.status_clear),
        .o_data(bus.out_data),
        .o_valid(bus.out_valid),
        .o_level(bus.fifo_level),
        .o_overflow(bus.overflow)
    );

endmodule
